// File: rtl/dio_loader.sv
// dio_loader: HPS ioctl byte stream -> SDRAM DIO slot download engine.
// Pairs bytes into words, maps each ioctl index to its own SDRAM region,
// stalls the HPS until each word lands in a DIO slot, and classifies
// floppy images by size into per-drive inserted / double-sided flags.

// Per-drive image flags; eject and download start win over classification.
module dio_drive_flag (
  input  logic clk_sys,
  input  logic n_reset,
  input  logic clr,
  input  logic load,
  input  logic ins_in,
  input  logic ds_in,
  input  logic eject,
  output logic ins,
  output logic ds
);

  // Hold flags; clear on eject/start, load on end of download.
  always_ff @(posedge clk_sys) begin
    if (!n_reset) begin
      ins <= 1'b0;
      ds  <= 1'b0;
    end else if (eject || clr) begin
      ins <= 1'b0;
      ds  <= 1'b0;
    end else if (load) begin
      ins <= ins_in;
      ds  <= ds_in;
    end
  end

endmodule

module dio_loader #(
  parameter int          NUM_DISKS  = 2,
  parameter logic [24:0] BASE_ADDR  = 25'h0200000,
  parameter logic [21:0] SLOT_WORDS = 22'h080000,
  parameter int          DS_BYTES   = 819200,
  parameter int          SS_BYTES   = 409600
) (
  input  logic                 clk_sys,
  input  logic                 n_reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic                 ioctl_wait,
  input  logic                 bus_slot,
  output logic                 mem_active,
  output logic [24:0]          mem_addr,
  output logic [15:0]          mem_din,
  output logic                 mem_we,
  input  logic [NUM_DISKS-1:0] disk_eject,
  output logic [NUM_DISKS-1:0] disk_ins,
  output logic [NUM_DISKS-1:0] disk_ds,
  output logic                 rom_valid,
  output logic                 ovf
);

  typedef enum logic [1:0] {IDLE, ARM, READY, WRITE} state_t;

  state_t      st;
  logic        dl_d;
  logic [7:0]  idx_r;
  logic [25:0] cnt;      // bytes seen this download = last ioctl_addr + 1
  logic [7:0]  hi;
  logic        flush_r;  // word in the FSM is the end-of-download flush

  logic        dl_rise, dl_fall, word_done, flush_go, src_hit;
  logic [7:0]  src_idx;
  logic [23:0] src_w;
  logic        idx_ok, w_ok, take, ovf_hit;
  logic        cls_ds, cls_ins;
  logic [NUM_DISKS-1:0] drv_start, drv_end;

  function automatic logic [24:0] map_addr(input logic [7:0] idx, input logic [23:0] w);
    map_addr = BASE_ADDR + 25'(idx) * 25'(SLOT_WORDS) + 25'(w);
  endfunction

  assign dl_rise   = ioctl_download & ~dl_d;
  assign dl_fall   = ~ioctl_download & dl_d;
  assign word_done = ioctl_download & ioctl_wr & ioctl_addr[0];
  // Odd length leaves a lone high byte that still has to reach memory.
  assign flush_go  = dl_fall & cnt[0];
  assign src_hit   = word_done | flush_go;
  assign src_idx   = flush_go ? idx_r : ioctl_index;
  assign src_w     = flush_go ? cnt[24:1] : ioctl_addr[24:1];
  assign idx_ok    = src_idx <= 8'(NUM_DISKS);
  assign w_ok      = src_w < 24'(SLOT_WORDS);
  // Flush may preempt a stale in-flight word; normal words need an idle FSM.
  assign take      = src_hit & idx_ok & w_ok & (flush_go | (st == IDLE));
  assign ovf_hit   = src_hit & idx_ok & ~w_ok;

  assign cls_ds  = cnt == 26'(DS_BYTES);
  assign cls_ins = cls_ds | (cnt == 26'(SS_BYTES));

  assign mem_active = ioctl_download & bus_slot;
  assign mem_we     = bus_slot & ((st == READY) | (st == WRITE)) & (ioctl_download | flush_r);

  // Write FSM plus download bookkeeping (pairing, byte count, ROM flag, overflow).
  always_ff @(posedge clk_sys) begin
    if (!n_reset) begin
      st         <= IDLE;
      ioctl_wait <= 1'b0;
      flush_r    <= 1'b0;
      dl_d       <= 1'b0;
      idx_r      <= '0;
      cnt        <= '0;
      hi         <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      rom_valid  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      dl_d <= ioctl_download;
      if (ioctl_download) idx_r <= ioctl_index;
      if (dl_rise) cnt <= '0;
      if (ioctl_download && ioctl_wr) cnt <= {1'b0, ioctl_addr} + 26'd1;
      if (ioctl_download && ioctl_wr && !ioctl_addr[0]) hi <= ioctl_dout;
      if (ovf_hit) ovf <= 1'b1;
      if (dl_fall && idx_r == 8'd0) rom_valid <= (cnt != 26'd0);

      if (take) begin
        mem_addr   <= map_addr(src_idx, src_w);
        mem_din    <= flush_go ? {hi, 8'h00} : {hi, ioctl_dout};
        flush_r    <= flush_go;
        ioctl_wait <= ~flush_go;
        st         <= ARM;
      end else begin
        case (st)
          ARM:   if (!bus_slot) st <= READY;
          READY: if (bus_slot) st <= WRITE;
          WRITE: if (!bus_slot) begin
                   st         <= IDLE;
                   ioctl_wait <= 1'b0;
                   flush_r    <= 1'b0;
                 end
          default: st <= IDLE;
        endcase
      end
    end
  end

  // Per-drive start / end-of-download strobes.
  for (genvar i = 0; i < NUM_DISKS; i++) begin : g_drv
    assign drv_start[i] = dl_rise & (ioctl_index == 8'(i + 1));
    assign drv_end[i]   = dl_fall & (idx_r == 8'(i + 1));
  end

  dio_drive_flag u_drv [NUM_DISKS-1:0] (
    .clk_sys (clk_sys),
    .n_reset (n_reset),
    .clr     (drv_start),
    .load    (drv_end),
    .ins_in  (cls_ins),
    .ds_in   (cls_ds),
    .eject   (disk_eject),
    .ins     (disk_ins),
    .ds      (disk_ds)
  );

endmodule

// File: doc/dio_loader.md
Name: dio_loader

Overview:
- Multi-channel download engine between the HPS ioctl byte stream and the SDRAM DIO bus slot.
- Pairs bytes into 16-bit words and maps each ioctl index to its own SDRAM region (index 0 = OS ROM, indices 1..NUM_DISKS = floppy images).
- Throttles the HPS with ioctl_wait until each word is written in a DIO slot.
- Classifies each disk image by size at end of download and maintains per-drive inserted / double-sided flags, cleared on eject.

Parameters:
- NUM_DISKS, 2: number of floppy image channels, 1..7.
- BASE_ADDR, 25'h0200000: SDRAM word address of the ROM region.
- SLOT_WORDS, 22'h080000: word size of each region; disk k region starts at BASE_ADDR + k*SLOT_WORDS.
- DS_BYTES, 819200: exact byte size of a double-sided image.
- SS_BYTES, 409600: exact byte size of a single-sided image.

Ports:
- clk_sys  in  1  system clock
- n_reset  in  1  synchronous active-low reset
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  target channel
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  byte address within file
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  stall to HPS
- bus_slot  in  1  high for the duration of a DIO memory slot
- mem_active  out  1  ioctl_download & bus_slot; steers SDRAM mux
- mem_addr  out  25  SDRAM word address
- mem_din  out  16  write data, high byte = even file byte
- mem_we  out  1  write enable
- disk_eject  in  NUM_DISKS  per-drive eject pulse from the controller
- disk_ins  out  NUM_DISKS  valid image inserted
- disk_ds  out  NUM_DISKS  inserted image is double-sided
- rom_valid  out  1  a non-empty ROM has been loaded
- ovf  out  1  sticky: a word was dropped because it exceeded its region

Behaviour:
- Reset:
  - state IDLE; ioctl_wait, mem_we, disk_ins, disk_ds, rom_valid and ovf all 0; the pending byte/word is discarded.
  - Reset mid-handshake drops the word; no write is issued.
- Byte pairing:
  - ioctl_wr with ioctl_addr[0]=0 latches the high byte.
  - ioctl_wr with ioctl_addr[0]=1 forms {hi, dout} at word address ioctl_addr[24:1].
- Address mapping:
  - Word offset w = ioctl_addr[24:1].
  - Index 0 maps to BASE_ADDR + w.
  - Index k (1..NUM_DISKS) maps to BASE_ADDR + k*SLOT_WORDS + w.
  - If w >= SLOT_WORDS: no write, no wait, ovf <= 1.
  - If index > NUM_DISKS: bytes are consumed, no write, no wait.
- Write FSM, states IDLE, ARM, READY, WRITE:
  - IDLE: on word completion, latch addr/data and go to ARM. ioctl_wait = 1 from the next cycle.
  - ARM: wait for bus_slot = 0, so the write never starts in a partially elapsed slot, then go to READY.
  - READY: when bus_slot = 1, go to WRITE.
  - WRITE: when bus_slot falls, return to IDLE and set ioctl_wait = 0 in the same cycle.
  - mem_we = bus_slot & (state == READY or WRITE); mem_addr and mem_din are held stable from ARM through WRITE.
- End of download (falling edge of ioctl_download):
  - byte count B = last ioctl_addr + 1, tracked per download.
  - Odd B: the pending high byte is flushed as {hi, 8'h00} at word (B-1)>>1 through the same FSM; ioctl_wait is not asserted for the flush.
  - Index k >= 1: disk_ds[k-1] <= (B == DS_BYTES); disk_ins[k-1] <= (B == DS_BYTES) | (B == SS_BYTES).
  - Index 0: rom_valid <= (B != 0).
- Start of download (rising edge) to index k >= 1: disk_ins[k-1] and disk_ds[k-1] cleared immediately, so the controller never sees a half-loaded image.
- Eject: disk_eject[j] clears disk_ins[j] and disk_ds[j]. Eject has priority over a same-cycle classification on that drive.
- ioctl_download low: mem_active = 0 and writes are never issued, except for a flush word that is already in the FSM.

Test Plan:
1. ROM download: index 0, bytes 12 34 56 78 with bus_slot pulsing 4-on/4-off -> writes 0x1234 at 0x0200000 and 0x5678 at 0x0200001. ioctl_wait rises one cycle after byte 1 and falls on the bus_slot falling edge. rom_valid = 1 at end.
2. Size classification: index 1 with DS_BYTES overridden to 8 and SS_BYTES to 4.
   - 8 bytes -> disk_ins[0] = 1, disk_ds[0] = 1.
   - 4 bytes to index 2 -> disk_ins[1] = 1, disk_ds[1] = 0.
   - 6 bytes to index 1 -> disk_ins[0] = 0.
3. Odd length: index 2, bytes AB CD EF -> writes 0xABCD at BASE+0x100000 and 0xEF00 at BASE+0x100001.
4. Late slot: bus_slot already high when a word completes -> no mem_we in the current slot; the write occurs in the next full slot.
5. Eject/reload: disk_ins[0] = 1; assert disk_eject[0] in the same cycle as an index-1 download end -> disk_ins[0] = 0. A new index-1 download start also clears disk_ins[0].
6. Reset in ARM state -> ioctl_wait = 0 the next cycle, no mem_we, all flags 0. Index 9 download -> no writes, ioctl_wait stays 0.
